// File: rtl/mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the multi-port memory controller:
//   - safe_clog2 : ceil(log2(n)) that never returns 0, so widths stay >= 1
//   - RD_LAT_MIN / RD_LAT_MAX : supported read-latency range
//   - PORT_IDX_W : width of a port index able to name any of up to 8 ports
//   - rd_tag_t   : read-pipeline entry {valid, originating port}
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = 3;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Control part of a read-pipeline entry. The data word travels in a
    // parallel array inside the controller because its width is a parameter
    // of each controller instance and cannot be fixed here.
    typedef struct packed {
        logic                  valid;
        logic [PORT_IDX_W-1:0] port;
    } rd_tag_t;

endpackage

// File: rtl/mem_ctrl_rr_arb.sv
// ----------------------------------------------------------------------------
// mem_ctrl_rr_arb
// Round-robin arbiter: grants at most one requester per cycle, searching
// upward from r_rr_ptr and wrapping. After a grant to port g the pointer
// moves to (g+1) mod NUM_PORTS; with no grant it holds. Nothing is granted
// while rst is high.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (r_rr_ptr <= 0)
//   i_req     : per-port request vector
//   o_grant   : one-hot grant (all zero when nobody requests)
//   o_gidx    : index of the granted port (meaningful only when |o_grant)
// ----------------------------------------------------------------------------
module mem_ctrl_rr_arb
    import mem_ctrl_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    localparam int PW        = safe_clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [PW-1:0]        o_gidx
);

    logic [PW-1:0] r_rr_ptr;
    logic          w_found;
    logic [PW-1:0] w_gidx;
    logic [PW-1:0] w_next_ptr;

    // Walk the ports in priority order ptr, ptr+1, ... (mod NUM_PORTS).
    // The sum is one bit wider so the wrap works for non-power-of-two counts.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        w_found = 1'b0;
        w_gidx  = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_PORTS)) begin
                sum = sum - (PW+1)'(NUM_PORTS);
            end
            idx = sum[PW-1:0];
            if (!w_found && !rst && i_req[idx]) begin
                w_found = 1'b1;
                w_gidx  = idx;
            end
        end
    end

    assign w_next_ptr = (w_gidx == PW'(NUM_PORTS - 1)) ? '0 : w_gidx + PW'(1);

    always_comb begin
        o_grant = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            o_grant[p] = w_found && (w_gidx == PW'(p));
        end
    end

    assign o_gidx = w_gidx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/mem_ctrl_arb.sv
// ----------------------------------------------------------------------------
// mem_ctrl_arb
// Multi-port front end to a single-ported word array. Each cycle at most one
// operation (read or write) from one port is accepted, chosen round-robin.
//
// Handshake: a port requests by raising mem_ren[p] and/or mem_wen[p] with its
// address/data. The matching mem_rready[p]/mem_wready[p] is driven
// combinationally in the same cycle; when it is high the operation is taken
// at that rising edge. A request that sees no ready is simply not taken; the
// requester may keep it up or drop it. If a granted port asks for both, the
// write wins and the read stays pending. Accepted reads return on
// mem_rdata_valid[p] exactly RD_LAT cycles after the accept cycle, and
// mem_rdata[p] holds that word until the next valid on the same port.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   mem_raddr/ren    : per-port read address / read request
//   mem_rready       : per-port read accepted this cycle
//   mem_rdata/valid  : per-port read data / one-cycle data strobe
//   mem_waddr/wdata  : per-port write address / write data
//   mem_wen/wready   : per-port write request / write accepted this cycle
// Writes to addresses >= MEM_DEPTH are accepted and dropped; reads from such
// addresses return 0. Array contents are not reset.
// ----------------------------------------------------------------------------
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
#(
    parameter  int NUM_PORTS  = 2,
    parameter  int MEM_DEPTH  = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int RD_LAT     = 1,
    localparam int AW         = safe_clog2(MEM_DEPTH),
    localparam int PW         = safe_clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*AW-1:0]         mem_raddr,
    input  logic [NUM_PORTS-1:0]            mem_ren,
    output logic [NUM_PORTS-1:0]            mem_rready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] mem_rdata,
    output logic [NUM_PORTS-1:0]            mem_rdata_valid,
    input  logic [NUM_PORTS*AW-1:0]         mem_waddr,
    input  logic [NUM_PORTS-1:0]            mem_wen,
    output logic [NUM_PORTS-1:0]            mem_wready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] mem_wdata
);

    // ---------------- arbitration ----------------
    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_grant;
    logic [PW-1:0]        w_gidx;

    assign w_req = mem_ren | mem_wen;

    mem_ctrl_rr_arb #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_req),
        .o_grant (w_grant),
        .o_gidx  (w_gidx)
    );

    // A grant implies a request, so a granted port without wen is a read.
    assign mem_wready = w_grant & mem_wen;
    assign mem_rready = w_grant & ~mem_wen;

    logic w_do_write;
    logic w_do_read;
    assign w_do_write = |mem_wready;
    assign w_do_read  = |mem_rready;

    // ---------------- granted port's operands ----------------
    logic [AW-1:0]         w_waddr;
    logic [AW-1:0]         w_raddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_w_inrange;
    logic                  w_r_inrange;

    assign w_waddr = mem_waddr[w_gidx*AW +: AW];
    assign w_raddr = mem_raddr[w_gidx*AW +: AW];
    assign w_wdata = mem_wdata[w_gidx*DATA_WIDTH +: DATA_WIDTH];

    // Extra leading zero keeps the compare meaningful for non-power-of-two depths.
    assign w_w_inrange = ({1'b0, w_waddr} < (AW+1)'(MEM_DEPTH));
    assign w_r_inrange = ({1'b0, w_raddr} < (AW+1)'(MEM_DEPTH));

    // ---------------- storage (never reset) ----------------
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] w_rd_data;

    always_ff @(posedge clk) begin
        if (w_do_write && w_w_inrange) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Sampled at the accept edge: every earlier accepted write is already in r_mem.
    assign w_rd_data = w_r_inrange ? r_mem[w_raddr] : '0;

    // ---------------- read pipeline ----------------
    rd_tag_t               r_pipe_tag  [RD_LAT];
    logic [DATA_WIDTH-1:0] r_pipe_data [RD_LAT];
    logic [DATA_WIDTH-1:0] r_rdata_hold [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_tag[i]  <= '0;
                r_pipe_data[i] <= '0;
            end
        end else begin
            r_pipe_tag[0].valid <= w_do_read;
            r_pipe_tag[0].port  <= PORT_IDX_W'(w_gidx);
            r_pipe_data[0]      <= w_rd_data;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_tag[i]  <= r_pipe_tag[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end
    end

    // The last stage is presented directly so data and strobe line up in the
    // same cycle; the hold register keeps the word visible afterwards.
    rd_tag_t               w_last_tag;
    logic [DATA_WIDTH-1:0] w_last_data;
    logic [NUM_PORTS-1:0]  w_rvalid;

    assign w_last_tag  = r_pipe_tag[RD_LAT-1];
    assign w_last_data = r_pipe_data[RD_LAT-1];

    always_comb begin
        w_rvalid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rvalid[p] = w_last_tag.valid && (w_last_tag.port == PORT_IDX_W'(p));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rdata_hold[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_rvalid[p]) begin
                    r_rdata_hold[p] <= w_last_data;
                end
            end
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            mem_rdata[p*DATA_WIDTH +: DATA_WIDTH] = w_rvalid[p] ? w_last_data : r_rdata_hold[p];
        end
    end

    assign mem_rdata_valid = w_rvalid;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// ----------------------------------------------------------------------------
// tb_mem_ctrl_arb
// Three two-port controllers run side by side from one clock:
//   inst 0: MEM_DEPTH=32, RD_LAT=1
//   inst 1: MEM_DEPTH=20, RD_LAT=3
//   inst 2: MEM_DEPTH=32, RD_LAT=2
// A reference model (word array, round-robin pointer as an integer, queues of
// expected read returns) predicts readies each cycle and pushes expected read
// data with its due cycle; a monitor pops and compares whenever a valid shows.
// ----------------------------------------------------------------------------
module tb_mem_ctrl_arb;

    localparam int NI = 3;
    localparam int NP = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              rst    [NI];
    logic [NP*AW-1:0]  raddr  [NI];
    logic [NP*AW-1:0]  waddr  [NI];
    logic [NP-1:0]     ren    [NI];
    logic [NP-1:0]     wen    [NI];
    logic [NP-1:0]     rready [NI];
    logic [NP-1:0]     wready [NI];
    logic [NP-1:0]     rvalid [NI];
    logic [NP*DW-1:0]  wdata  [NI];
    logic [NP*DW-1:0]  rdata  [NI];

    mem_ctrl_arb #(.NUM_PORTS(NP), .MEM_DEPTH(32), .DATA_WIDTH(DW), .RD_LAT(1)) dut0 (
        .clk(clk), .rst(rst[0]), .mem_raddr(raddr[0]), .mem_ren(ren[0]),
        .mem_rready(rready[0]), .mem_rdata(rdata[0]), .mem_rdata_valid(rvalid[0]),
        .mem_waddr(waddr[0]), .mem_wen(wen[0]), .mem_wready(wready[0]), .mem_wdata(wdata[0])
    );

    mem_ctrl_arb #(.NUM_PORTS(NP), .MEM_DEPTH(20), .DATA_WIDTH(DW), .RD_LAT(3)) dut1 (
        .clk(clk), .rst(rst[1]), .mem_raddr(raddr[1]), .mem_ren(ren[1]),
        .mem_rready(rready[1]), .mem_rdata(rdata[1]), .mem_rdata_valid(rvalid[1]),
        .mem_waddr(waddr[1]), .mem_wen(wen[1]), .mem_wready(wready[1]), .mem_wdata(wdata[1])
    );

    mem_ctrl_arb #(.NUM_PORTS(NP), .MEM_DEPTH(32), .DATA_WIDTH(DW), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst[2]), .mem_raddr(raddr[2]), .mem_ren(ren[2]),
        .mem_rready(rready[2]), .mem_rdata(rdata[2]), .mem_rdata_valid(rvalid[2]),
        .mem_waddr(waddr[2]), .mem_wen(wen[2]), .mem_wready(wready[2]), .mem_wdata(wdata[2])
    );

    // ---------------- reference model state ----------------
    int          lat_of   [NI];
    int          depth_of [NI];
    logic [DW-1:0] mem_m  [NI][32];
    int          ptr_m    [NI];
    logic [DW-1:0] hold_m [NI*NP];
    logic [DW-1:0] exp_q  [NI*NP][$];
    int          exp_t_q  [NI*NP][$];
    int          rd_cnt   [NI][NP];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict this cycle's accept for instance k from the driven inputs and
    // compare with the DUT's readies; apply the accepted operation to the model.
    task automatic eval_inst(input int k);
        logic [NP-1:0] req;
        logic [NP-1:0] er;
        logic [NP-1:0] ew;
        int            g;
        int            a;
        er = '0;
        ew = '0;
        for (int p = 0; p < NP; p++) rd_cnt[k][p] += int'(rready[k][p]);
        if (rst[k]) begin
            ptr_m[k] = 0;
            for (int p = 0; p < NP; p++) begin
                exp_q[k*NP+p].delete();
                exp_t_q[k*NP+p].delete();
                hold_m[k*NP+p] = '0;
            end
        end else begin
            req = ren[k] | wen[k];
            g   = -1;
            for (int i = 0; i < NP; i++) begin
                int idx;
                idx = (ptr_m[k] + i) % NP;
                if (g < 0 && req[idx]) g = idx;
            end
            if (g >= 0) begin
                if (wen[k][g]) begin
                    ew[g] = 1'b1;
                    a = int'(waddr[k][g*AW +: AW]);
                    if (a < depth_of[k]) mem_m[k][a] = wdata[k][g*DW +: DW];
                end else begin
                    er[g] = 1'b1;
                    a = int'(raddr[k][g*AW +: AW]);
                    exp_q[k*NP+g].push_back((a < depth_of[k]) ? mem_m[k][a] : '0);
                    exp_t_q[k*NP+g].push_back(cyc + lat_of[k]);
                end
                ptr_m[k] = (g + 1) % NP;
            end
        end
        check($sformatf("ready_i%0d", k), {rready[k], wready[k]}, {er, ew});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < NP; p++) begin
                int q;
                q = k*NP + p;
                if (rvalid[k][p]) begin
                    if (exp_q[q].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_valid_i%0d_p%0d: got valid=1 expected none (cycle %0d)", k, p, cyc);
                    end else begin
                        check($sformatf("valid_cycle_i%0d_p%0d", k, p), 64'(cyc), 64'(exp_t_q[q][0]));
                        hold_m[q] = exp_q[q][0];
                        void'(exp_q[q].pop_front());
                        void'(exp_t_q[q].pop_front());
                    end
                end else if (exp_t_q[q].size() > 0 && exp_t_q[q][0] <= cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missing_valid_i%0d_p%0d: got valid=0 expected 1 (cycle %0d)", k, p, cyc);
                    void'(exp_q[q].pop_front());
                    void'(exp_t_q[q].pop_front());
                end
                check($sformatf("rdata_i%0d_p%0d", k, p), 64'(rdata[k][p*DW +: DW]), 64'(hold_m[q]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            ren[k]   = '0;
            wen[k]   = '0;
            raddr[k] = '0;
            waddr[k] = '0;
            wdata[k] = '0;
        end
    endtask

    task automatic set_rd(input int k, input int p, input int a);
        ren[k][p]            = 1'b1;
        raddr[k][p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int k, input int p, input int a, input logic [DW-1:0] d);
        wen[k][p]            = 1'b1;
        waddr[k][p*AW +: AW] = AW'(a);
        wdata[k][p*DW +: DW] = d;
    endtask

    // Inputs are set just after a negedge; evaluate, then move to the next one.
    task automatic step();
        #1;
        for (int k = 0; k < NI; k++) eval_inst(k);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            idle_all();
            step();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        lat_of   = '{1, 3, 2};
        depth_of = '{32, 20, 32};
        for (int k = 0; k < NI; k++) begin
            ptr_m[k] = 0;
            rst[k]   = 1'b1;
            for (int p = 0; p < NP; p++) begin
                hold_m[k*NP+p] = '0;
                rd_cnt[k][p]   = 0;
            end
        end
        idle_all();
        @(negedge clk);
        step();
        step();
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;

        // Known contents everywhere; inst 1 also sees writes past its depth.
        for (int a = 0; a < 32; a++) begin
            idle_all();
            for (int k = 0; k < NI; k++) set_wr(k, 0, a, $urandom);
            step();
        end

        // p0 writes, p1 reads it back one cycle after accept.
        idle_all(); set_wr(0, 0, 5, 32'hDEAD_BEEF); step();
        idle_all(); set_rd(0, 1, 5); step();
        idle_steps(3);

        // Both ports reading continuously from reset share grants evenly.
        idle_all(); rst[0] = 1'b1; step(); rst[0] = 1'b0;
        for (int p = 0; p < NP; p++) rd_cnt[0][p] = 0;
        for (int i = 0; i < 100; i++) begin
            idle_all();
            set_rd(0, 0, $urandom_range(0, 31));
            set_rd(0, 1, $urandom_range(0, 31));
            step();
        end
        check("rr_share_p0", 64'(rd_cnt[0][0]), 64'd50);
        check("rr_share_p1", 64'(rd_cnt[0][1]), 64'd50);
        idle_steps(3);

        // Write wins over a simultaneous read; the read follows next cycle.
        idle_all(); set_wr(0, 0, 3, 32'h12); set_rd(0, 0, 3); step();
        check("wr_first_wready", 64'(wready[0]), 64'b01);
        idle_all(); set_rd(0, 0, 3); step();
        idle_steps(3);

        // Back-to-back reads with RD_LAT=3.
        for (int a = 0; a < 4; a++) begin
            idle_all(); set_rd(1, 0, a); step();
        end
        idle_steps(5);

        // Out-of-range write dropped, out-of-range read returns 0.
        idle_all(); set_wr(1, 1, 5, 32'hA5A5_0005); step();
        idle_all(); set_wr(1, 0, 25, 32'h55); step();
        idle_all(); set_rd(1, 1, 25); step();
        idle_all(); set_rd(1, 0, 5); step();
        idle_steps(5);

        // Reset right after a read accept drops the read.
        idle_all(); set_rd(2, 0, 7); step();
        idle_all(); rst[2] = 1'b1; step();
        rst[2] = 1'b0;
        check("rr_ptr_after_rst", 64'(dut2.u_arb.r_rr_ptr), 64'd0);
        check("rdata_after_rst", 64'(rdata[2]), 64'd0);
        idle_steps(4);

        // Randomized traffic on all instances with occasional resets.
        for (int i = 0; i < 400; i++) begin
            idle_all();
            for (int k = 0; k < NI; k++) begin
                rst[k] = ($urandom_range(0, 39) == 0);
                for (int p = 0; p < NP; p++) begin
                    if ($urandom_range(0, 2) != 0) set_rd(k, p, $urandom_range(0, 31));
                    if ($urandom_range(0, 3) == 0) set_wr(k, p, $urandom_range(0, 31), $urandom);
                end
            end
            step();
        end
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        idle_steps(8);

        for (int q = 0; q < NI*NP; q++) begin
            check($sformatf("drain_q%0d", q), 64'(exp_q[q].size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
